// File: rtl/program_loader.sv
// Program memory loader: accepts a header/data/checksum byte stream, packs it into 16-bit words
// and holds the CPU core in reset until a verified image is in place.
module program_loader #(
    parameter int unsigned PC_WIDTH = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                pm_we,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic [15:0]         pm_wdata,
    output logic                core_hold,
    output logic                done,
    output logic                error,
    output logic [PC_WIDTH:0]   words_loaded
);

    localparam int unsigned MaxHdr = (1 << PC_WIDTH) - 1;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StHi,
        StLo,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e            state;
    logic [PC_WIDTH:0] hdr;
    logic [7:0]        chk;
    logic [7:0]        hi_byte;
    logic              xfer;
    logic              last_word;

    assign xfer = in_valid && in_ready;
    // pm_addr already points at the word being assembled when its low byte arrives
    assign last_word = (hdr == {1'b0, pm_addr});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            in_ready     <= 1'b0;
            pm_we        <= 1'b0;
            pm_addr      <= '0;
            pm_wdata     <= '0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            hdr          <= '0;
            chk          <= '0;
            hi_byte      <= '0;
        end else begin
            pm_we <= 1'b0;
            // Advance the write pointer the cycle after each write; hold at the top after a full load
            if (pm_we) begin
                if (pm_addr != '1) begin
                    pm_addr <= pm_addr + 1'b1;
                end
                words_loaded <= words_loaded + 1'b1;
            end

            case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state        <= StHdr;
                        in_ready     <= 1'b1;
                        core_hold    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        pm_addr      <= '0;
                        chk          <= '0;
                    end
                end
                StHdr: begin
                    if (xfer) begin
                        if (32'(in_byte) > MaxHdr) begin
                            state    <= StErr;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            hdr   <= (PC_WIDTH + 1)'(in_byte);
                            chk   <= chk ^ in_byte;
                            state <= StHi;
                        end
                    end
                end
                StHi: begin
                    if (xfer) begin
                        hi_byte <= in_byte;
                        chk     <= chk ^ in_byte;
                        state   <= StLo;
                    end
                end
                StLo: begin
                    if (xfer) begin
                        chk      <= chk ^ in_byte;
                        pm_we    <= 1'b1;
                        pm_wdata <= {hi_byte, in_byte};
                        state    <= last_word ? StChk : StHi;
                    end
                end
                StChk: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_byte == chk) begin
                            state     <= StDone;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader; expected writes and status come from a
// stream-level model that parses header, data words and checksum directly.
module tb_program_loader;

    localparam int PCW = 6;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     in_byte = 8'h00;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           pm_we;
    logic [PCW-1:0] pm_addr;
    logic [15:0]    pm_wdata;
    logic           core_hold;
    logic           done;
    logic           error;
    logic [PCW:0]   words_loaded;

    program_loader #(.PC_WIDTH(PCW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pm_we        (pm_we),
        .pm_addr      (pm_addr),
        .pm_wdata     (pm_wdata),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [PCW-1:0] got_addr[$];
    logic [15:0]    got_data[$];
    logic [PCW-1:0] exp_addr[$];
    logic [15:0]    exp_data[$];
    logic [7:0]     stream[$];
    logic           exp_done;
    logic           exp_err;
    int             exp_words;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (pm_we) begin
            got_addr.push_back(pm_addr);
            got_data.push_back(pm_wdata);
            check("pm_addr_in_range", 32'(pm_addr <= 6'd63), 32'd1);
        end
    end

    // Reference: interpret the byte stream as the loader protocol describes it
    task automatic model_stream();
        int h;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        h = int'(stream[0]);
        if (h >= (1 << PCW)) begin
            exp_err = 1'b1;
            exp_done = 1'b0;
            exp_words = 0;
        end else begin
            x = stream[0];
            for (int i = 0; i <= h; i++) begin
                exp_addr.push_back(PCW'(i));
                exp_data.push_back({stream[1 + 2 * i], stream[2 + 2 * i]});
                x = x ^ stream[1 + 2 * i] ^ stream[2 + 2 * i];
            end
            exp_done = (x == stream[2 * h + 3]);
            exp_err = !exp_done;
            exp_words = h + 1;
        end
    endtask

    task automatic build_stream(input int h, input bit index_data, input bit bad_chk);
        logic [7:0] x;
        logic [15:0] w;
        stream.delete();
        stream.push_back(8'(h));
        if (h < (1 << PCW)) begin
            x = 8'(h);
            for (int i = 0; i <= h; i++) begin
                w = index_data ? 16'(i) : 16'($urandom);
                stream.push_back(w[15:8]);
                stream.push_back(w[7:0]);
                x = x ^ w[15:8] ^ w[7:0];
            end
            stream.push_back(bad_chk ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noise_start);
        int gaps;
        int n;
        gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        repeat (gaps) begin
            in_valid = 1'b0;
            in_byte = 8'($urandom);
            start = noise_start ? 1'($urandom_range(1, 0)) : 1'b0;
            @(negedge clock);
        end
        start = 1'b0;
        in_byte = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        got_addr.delete();
        got_data.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_stream(input int gap_max, input bit noise_start);
        foreach (stream[i]) send_byte(stream[i], gap_max, noise_start);
    endtask

    task automatic finish_and_check(input string tag);
        repeat (3) @(negedge clock);
        model_stream();
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_core_hold"}, 32'(core_hold), 32'(!exp_done));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
        check({tag, "_write_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        if (got_addr.size() == exp_addr.size()) begin
            foreach (exp_addr[i]) begin
                check({tag, "_waddr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
                check({tag, "_wdata"}, 32'(got_data[i]), 32'(exp_data[i]));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        check({tag, "_pm_we"}, 32'(pm_we), 32'd0);
        check({tag, "_pm_addr"}, 32'(pm_addr), 32'd0);
        check({tag, "_pm_wdata"}, 32'(pm_wdata), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic set_s1(input logic [7:0] chk_byte);
        stream.delete();
        stream.push_back(8'h01);
        stream.push_back(8'h12);
        stream.push_back(8'h34);
        stream.push_back(8'hAB);
        stream.push_back(8'hCD);
        stream.push_back(chk_byte);
    endtask

    initial begin
        int h;
        int wl_before;
        // Reset state
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clock);

        // Scenario 1: basic two-word load
        set_s1(8'h41);
        do_start();
        run_stream(0, 1'b0);
        finish_and_check("s1");
        check("s1_words_const", 32'(words_loaded), 32'd2);
        check("s1_done_const", 32'(done), 32'd1);

        // Scenario 2: bad checksum, then a clean reload
        set_s1(8'h40);
        do_start();
        run_stream(0, 1'b0);
        finish_and_check("s2_bad");
        check("s2_error_const", 32'(error), 32'd1);
        set_s1(8'h41);
        do_start();
        run_stream(0, 1'b0);
        finish_and_check("s2_good");

        // Scenario 3: oversized header
        stream.delete();
        stream.push_back(8'h40);
        do_start();
        send_byte(8'h40, 0, 1'b0);
        check("s3_error_next_cycle", 32'(error), 32'd1);
        check("s3_in_ready", 32'(in_ready), 32'd0);
        finish_and_check("s3");

        // Scenario 4: full-capacity load, data = index
        build_stream(63, 1'b1, 1'b0);
        do_start();
        run_stream(0, 1'b0);
        finish_and_check("s4");
        check("s4_words_const", 32'(words_loaded), 32'd64);

        // Scenario 5: bytes offered in IDLE and DONE, gaps and stray start pulses mid-load
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_byte = 8'($urandom);
            @(negedge clock);
            check("s5_idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        set_s1(8'h41);
        do_start();
        run_stream(3, 1'b1);
        finish_and_check("s5");
        wl_before = int'(words_loaded);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_byte = 8'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("s5_done_hold", 32'(done), 32'd1);
        check("s5_done_words", 32'(words_loaded), 32'(wl_before));
        check("s5_done_no_writes", 32'(got_addr.size()), 32'd2);

        // Scenario 6: async reset mid-load, then a clean load
        set_s1(8'h41);
        do_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 0, 1'b0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("s6_async");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_start();
        run_stream(0, 1'b0);
        finish_and_check("s6");

        // Randomized loads
        for (int it = 0; it < 20; it++) begin
            h = ($urandom_range(7, 0) == 0) ? int'($urandom_range(255, 64))
                                            : int'($urandom_range(9, 0));
            build_stream(h, 1'b0, ($urandom_range(3, 0) == 0));
            do_start();
            run_stream(2, 1'b1);
            finish_and_check("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program memory. Receives a byte stream over a valid/ready handshake, packs bytes into 16-bit instruction words and writes them sequentially into writable program memory from address 0.
- Holds the CPU core in reset until a complete image with a correct checksum has been written; the core then reads the image through its PC.

Parameters:
PC_WIDTH, 6, program memory address width; capacity 2^PC_WIDTH words

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
in_byte  input  8  stream byte
in_valid  input  1  in_byte is valid
in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready
pm_we  output  1  program memory write strobe, one cycle per word
pm_addr  output  PC_WIDTH  program memory write address
pm_wdata  output  16  program memory write data {high byte, low byte}
core_hold  output  1  1 = keep cpu_core in reset
done  output  1  image loaded and verified
error  output  1  load failed (bad header or checksum)
words_loaded  output  PC_WIDTH+1  count of words written in the current or last load

Behaviour:
- Reset (reset=0, async):
  - State = IDLE. core_hold=1; pm_we=0; pm_addr=0; pm_wdata=0; in_ready=0; done=0; error=0; words_loaded=0.
  - Internal count, checksum and byte registers cleared.
- States: IDLE, HDR, HI, LO, CHK, DONE, ERR. All outputs are registered.
- in_ready = 1 only in HDR, HI, LO and CHK.
- IDLE/DONE/ERR + start=1 -> HDR on the next edge. On the same edge: core_hold=1, done=0, error=0, words_loaded=0, pm_addr=0, checksum=0. start is ignored in every other state.
- HDR, byte accepted: header H = number of words minus 1.
  - If H >= 2^PC_WIDTH -> ERR.
  - Otherwise store H, checksum ^= H, -> HI.
- HI, byte accepted: latch as high byte, checksum ^= byte, -> LO.
- LO, byte accepted: checksum ^= byte.
  - On the next cycle: pm_we=1 for exactly one cycle, pm_wdata={hi,lo}, pm_addr=current word index.
  - One cycle later: pm_addr increments and words_loaded increments.
  - If the word just accepted is word H -> CHK, otherwise -> HI.
  - A new HI byte may be accepted during the pm_we cycle; no stall.
- CHK, byte accepted:
  - byte == checksum -> DONE: done=1, core_hold=0 on the next edge.
  - Mismatch -> ERR: error=1, core_hold stays 1.
- DONE and ERR are held until start or reset. In ERR, the memory contents written so far remain; core_hold stays 1.
- in_valid while in_ready=0 is ignored; bytes are not buffered.
- in_valid low mid-load: the loader waits indefinitely in its current state.
- Address arithmetic: pm_addr never wraps within a load, because H < 2^PC_WIDTH. words_loaded is one bit wider, so a full load of 2^PC_WIDTH words is representable.
- Reset mid-load: immediately returns to IDLE with core_hold=1; a partial image is not marked valid.
- Checksum = XOR of the header byte and all data bytes, 8-bit.

Test Plan:
1. Reset, then start, then bytes 01 12 34 AB CD 41 (one per cycle) -> pm_we pulses twice: addr0=0x1234, addr1=0xABCD. Then done=1, core_hold=0, words_loaded=2, error=0.
2. Same stream with checksum 0x40 -> error=1, done=0, core_hold=1. Then start followed by the correct stream -> done=1.
3. PC_WIDTH=6, header 0x40 -> error=1 on the cycle after the header; in_ready=0 afterwards; no pm_we.
4. Full load: header 0x3F, 64 words with data = index, correct checksum -> 64 pm_we pulses at addresses 0..63; words_loaded=64; done=1; pm_addr never exceeds 63 on any pm_we.
5. Random in_valid gaps and bytes driven while in_ready=0 (in IDLE and DONE) -> identical memory writes to scenario 1; out-of-state bytes never consumed; start pulses during HI and LO ignored.
6. Assert reset after 3 data bytes of scenario 1 -> all outputs return to reset values asynchronously; later start plus the full stream -> clean load with done=1.
